// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder/loader.
// Takes one symbolic instruction per valid/ready handshake, assembles the
// 32-bit word and writes it through a registered imem write port at
// consecutive word addresses starting at BASE_ADDR.
// Optional build macro: ENC_CHECKSUM_EN adds a running XOR checksum output.
module instr_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          err
`ifdef ENC_CHECKSUM_EN
   ,output logic [31:0]   checksum
`endif
);

    localparam logic [4:0] MN_ILLEGAL = 5'd31;

    logic [31:0] enc;
    logic        accept;
    logic        legal;

    function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                           input logic [4:0] f_rd, input logic [4:0] f_sh,
                                           input logic [5:0] funct);
        return {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {op, f_rs, f_rt, f_imm};
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign in_ready = ~full & ~clear;
    assign accept   = in_valid & in_ready;
    assign legal    = (mnem != MN_ILLEGAL);

    // Assemble the instruction word; fields unused by a format are forced to zero.
    always_comb begin
        enc = 32'h0;
        case (mnem)
            5'd0:  enc = r_word(rs, rt, rd, 5'd0, 6'h20);
            5'd1:  enc = r_word(rs, rt, rd, 5'd0, 6'h21);
            5'd2:  enc = r_word(rs, rt, rd, 5'd0, 6'h22);
            5'd3:  enc = r_word(rs, rt, rd, 5'd0, 6'h23);
            5'd4:  enc = r_word(rs, rt, rd, 5'd0, 6'h24);
            5'd5:  enc = r_word(rs, rt, rd, 5'd0, 6'h25);
            5'd6:  enc = r_word(rs, rt, rd, 5'd0, 6'h26);
            5'd7:  enc = r_word(rs, rt, rd, 5'd0, 6'h27);
            5'd8:  enc = r_word(rs, rt, rd, 5'd0, 6'h2A);
            5'd9:  enc = r_word(rs, rt, rd, 5'd0, 6'h2B);
            5'd10: enc = r_word(5'd0, rt, rd, shamt, 6'h00);
            5'd11: enc = r_word(5'd0, rt, rd, shamt, 6'h02);
            5'd12: enc = r_word(5'd0, rt, rd, shamt, 6'h03);
            5'd13: enc = r_word(rs, rt, rd, 5'd0, 6'h04);
            5'd14: enc = r_word(rs, rt, rd, 5'd0, 6'h06);
            5'd15: enc = r_word(rs, rt, rd, 5'd0, 6'h07);
            5'd16: enc = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h08);
            5'd17: enc = i_word(6'h08, rs, rt, imm);
            5'd18: enc = i_word(6'h09, rs, rt, imm);
            5'd19: enc = i_word(6'h0C, rs, rt, imm);
            5'd20: enc = i_word(6'h0D, rs, rt, imm);
            5'd21: enc = i_word(6'h0E, rs, rt, imm);
            5'd22: enc = i_word(6'h23, rs, rt, imm);
            5'd23: enc = i_word(6'h2B, rs, rt, imm);
            5'd24: enc = i_word(6'h04, rs, rt, imm);
            5'd25: enc = i_word(6'h05, rs, rt, imm);
            5'd26: enc = i_word(6'h0A, rs, rt, imm);
            5'd27: enc = i_word(6'h0B, rs, rt, imm);
            5'd28: enc = i_word(6'h0F, 5'd0, rt, imm);
            5'd29: enc = {6'h02, target};
            5'd30: enc = {6'h03, target};
            default: enc = 32'h0;
        endcase
    end

    // Write port, word counter and sticky illegal flag; clear wins over an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0;
            count      <= '0;
            err        <= 1'b0;
        end else if (clear) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= enc;
                    imem_addr  <= BASE_ADDR + (32'(count) << 2);
                    count      <= count + CW'(1);
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef ENC_CHECKSUM_EN
    // Fold each word into the checksum on the edge where its strobe is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= 32'h0;
        end else if (clear) begin
            checksum <= 32'h0;
        end else if (imem_we) begin
            checksum <= checksum ^ imem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of hand-encoded instructions driven through
// a default-size instance, scoreboard of {addr, word} popped on each strobe,
// plus hand sequences for illegal/clear, a DEPTH=4 fill and async reset.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] word;
    } vec_t;

    logic        clk, rst, clear, in_valid, in_ready;
    logic        clear_s, in_valid_s, in_ready_s;
    logic [4:0]  mnem, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        imem_we, imem_we_s;
    logic [31:0] imem_addr, imem_wdata, imem_addr_s, imem_wdata_s;
    logic [6:0]  count;
    logic [2:0]  count_s;
    logic        full, err, full_s, err_s;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum, checksum_s;
`endif

    int n_vec = 0;
    int n_miss = 0;
    int exp_cnt = 0;
    int cnt_s = 0;
    int n_strobe_s = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_s[$];
    vec_t vecs[22];
    vec_t ill;

    instr_encoder #(.DEPTH(64), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
`ifdef ENC_CHECKSUM_EN
       ,.checksum(checksum)
`endif
    );

    instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) u_small (
        .clk(clk), .rst(rst), .clear(clear_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
        .count(count_s), .full(full_s), .err(err_s)
`ifdef ENC_CHECKSUM_EN
       ,.checksum(checksum_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic put(input vec_t v);
        mnem = v.mnem; rs = v.rs; rt = v.rt; rd = v.rd;
        shamt = v.shamt; imm = v.imm; target = v.target;
    endtask

    // Drive one instruction into the main instance for one cycle, recording what it should write.
    task automatic send(input vec_t v);
        put(v);
        in_valid = 1'b1;
        if (v.mnem != 5'd31) begin
            sb.push_back({32'(BASE + 32'(exp_cnt * 4)), v.word});
            exp_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Main instance scoreboard: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("imem_addr", imem_addr, e[63:32]);
                chk("imem_wdata", imem_wdata, e[31:0]);
            end
        end
    end

    // Small instance scoreboard.
    always @(negedge clk) begin
        if (!rst && imem_we_s) begin
            n_strobe_s++;
            if (sb_s.size() == 0) begin
                chk("small_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb_s.pop_front();
                chk("small_addr", imem_addr_s, e[63:32]);
                chk("small_wdata", imem_wdata_s, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00221820};
        vecs[1]  = '{5'd17, 5'd0,  5'd8,  5'd7,  5'd7,  16'h0005, 26'h0,       32'h20080005};
        vecs[2]  = '{5'd22, 5'd8,  5'd9,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h8D090004};
        vecs[3]  = '{5'd10, 5'd7,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h000110C0};
        vecs[4]  = '{5'd29, 5'd3,  5'd3,  5'd3,  5'd3,  16'hFFFF, 26'h10,      32'h08000010};
        vecs[5]  = '{5'd2,  5'd4,  5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,       32'h00853022};
        vecs[6]  = '{5'd7,  5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF827};
        vecs[7]  = '{5'd12, 5'd3,  5'd4,  5'd5,  5'd31, 16'h0000, 26'h0,       32'h00042FC3};
        vecs[8]  = '{5'd14, 5'd1,  5'd2,  5'd3,  5'd9,  16'h0000, 26'h0,       32'h00221806};
        vecs[9]  = '{5'd16, 5'd31, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h03E00008};
        vecs[10] = '{5'd9,  5'd2,  5'd3,  5'd4,  5'd0,  16'h0000, 26'h0,       32'h0043202B};
        vecs[11] = '{5'd20, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'h0,       32'h3422FFFF};
        vecs[12] = '{5'd23, 5'd29, 5'd31, 5'd0,  5'd0,  16'h8000, 26'h0,       32'hAFBF8000};
        vecs[13] = '{5'd24, 5'd1,  5'd2,  5'd9,  5'd9,  16'hFFFE, 26'h0,       32'h1022FFFE};
        vecs[14] = '{5'd28, 5'd5,  5'd3,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h3C031234};
        vecs[15] = '{5'd30, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        vecs[16] = '{5'd27, 5'd7,  5'd8,  5'd0,  5'd0,  16'h0001, 26'h0,       32'h2CE80001};
        vecs[17] = '{5'd6,  5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       32'h00000026};
        vecs[18] = '{5'd25, 5'd2,  5'd0,  5'd0,  5'd0,  16'h0003, 26'h0,       32'h14400003};
        vecs[19] = '{5'd19, 5'd3,  5'd4,  5'd0,  5'd0,  16'h00FF, 26'h0,       32'h306400FF};
        vecs[20] = '{5'd13, 5'd6,  5'd7,  5'd8,  5'd5,  16'h0000, 26'h0,       32'h00C74004};
        vecs[21] = '{5'd1,  5'd0,  5'd0,  5'd1,  5'd5,  16'h0000, 26'h0,       32'h00000821};
        ill      = '{5'd31, 5'd1,  5'd2,  5'd3,  5'd4,  16'h5555, 26'h0,       32'h00000000};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; clear_s = 1'b0; in_valid_s = 1'b0;
        put(vecs[0]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef ENC_CHECKSUM_EN
        chk("rst_checksum", checksum, 32'h0);
`endif

        // first write: latency one cycle
        @(posedge clk); #1;
        send(vecs[0]);
        @(negedge clk);
        chk("first_we", 32'(imem_we), 32'd1);
        chk("first_count", 32'(count), 32'd1);

        // remaining table back-to-back
        for (int i = 1; i < 22; i++) send(vecs[i]);
        @(negedge clk);
        @(negedge clk);
        chk("table_count", 32'(count), 32'(exp_cnt));
        chk("table_drained", 32'(sb.size()), 32'd0);
        chk("idle_we", 32'(imem_we), 32'd0);
        chk("hold_wdata", imem_wdata, vecs[21].word);
        chk("hold_addr", imem_addr, 32'(BASE + 32'((exp_cnt - 1) * 4)));
        chk("table_err", 32'(err), 32'd0);

        // j then illegal
        @(posedge clk); #1;
        send(vecs[4]);
        send(ill);
        @(negedge clk);
        chk("illegal_we", 32'(imem_we), 32'd0);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'(exp_cnt));
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);

        // clear dominates a same-cycle valid
        put(vecs[2]);
        in_valid = 1'b1;
        clear = 1'b1;
        #1;
        chk("clear_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_we", 32'(imem_we), 32'd0);
        chk("clear_addr", imem_addr, BASE);
`ifdef ENC_CHECKSUM_EN
        chk("clear_checksum", checksum, 32'h0);
`endif
        @(posedge clk); #1;
        send(vecs[0]);
        send(vecs[1]);
        @(posedge clk);
        @(negedge clk);
`ifdef ENC_CHECKSUM_EN
        chk("checksum", checksum, 32'h202A1825);
`endif
        chk("after_clear_count", 32'(count), 32'd2);

        // DEPTH=4 instance: six valid cycles, only four accepted
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            put(vecs[i]);
            in_valid_s = 1'b1;
            chk("small_ready", 32'(in_ready_s), (cnt_s < 4) ? 32'd1 : 32'd0);
            if (i >= 4) chk("small_full_early", 32'(full_s), 32'd1);
            if (cnt_s < 4) begin
                sb_s.push_back({32'(BASE + 32'(cnt_s * 4)), vecs[i].word});
                cnt_s++;
            end
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("small_full", 32'(full_s), 32'd1);
        chk("small_ready_end", 32'(in_ready_s), 32'd0);
        chk("small_count", 32'(count_s), 32'd4);
        chk("small_strobes", 32'(n_strobe_s), 32'd4);
        chk("small_drained", 32'(sb_s.size()), 32'd0);

        // async reset mid-stream with err set and a strobe pending
        @(posedge clk); #1;
        send(ill);
        send(vecs[6]);
        send(vecs[7]);
        put(vecs[8]);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_addr", imem_addr, BASE);
        chk("arst_wdata", imem_wdata, 32'h0);
        chk("arst_small_full", 32'(full_s), 32'd0);
        chk("arst_small_count", 32'(count_s), 32'd0);
        sb.delete();
        sb_s.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back({BASE, vecs[8].word});
        exp_cnt = 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
